bus_matching_arbiter: RTL

Two-port round-robin arbiter sharing one downstream memory bus between requester port 0 and port 1. Every granted command gets a 1-bit port tag pushed into an internal in-order tag queue. Each downstream response pops that queue and is routed back to the tagged port. The block sits between two bus masters (e.g. instruction and data fetch) and a single in-order memory interface.

---
 rtl/bus_matching_arbiter_if.sv | 53 +++++
 rtl/bus_matching_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bus_matching_arbiter_if.sv
// Signal bundle between the two requester ports, the arbiter and the shared
// downstream memory bus. The arbiter uses the slave view; whatever drives
// the requesters and the memory model uses the master view.
interface bus_matching_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          iFLASH;

    logic          iP0_REQ;
    logic          iP0_RW;
    logic [AW-1:0] iP0_ADDR;
    logic [DW-1:0] iP0_DATA;
    logic          oP0_BUSY;
    logic          oP0_VALID;
    logic [DW-1:0] oP0_DATA;

    logic          iP1_REQ;
    logic          iP1_RW;
    logic [AW-1:0] iP1_ADDR;
    logic [DW-1:0] iP1_DATA;
    logic          oP1_BUSY;
    logic          oP1_VALID;
    logic [DW-1:0] oP1_DATA;

    logic          oBUS_REQ;
    logic          oBUS_RW;
    logic [AW-1:0] oBUS_ADDR;
    logic [DW-1:0] oBUS_DATA;
    logic          iBUS_BUSY;
    logic          iBUS_VALID;
    logic [DW-1:0] iBUS_DATA;

    modport slave (
        input  iFLASH,
        input  iP0_REQ, iP0_RW, iP0_ADDR, iP0_DATA,
        output oP0_BUSY, oP0_VALID, oP0_DATA,
        input  iP1_REQ, iP1_RW, iP1_ADDR, iP1_DATA,
        output oP1_BUSY, oP1_VALID, oP1_DATA,
        output oBUS_REQ, oBUS_RW, oBUS_ADDR, oBUS_DATA,
        input  iBUS_BUSY, iBUS_VALID, iBUS_DATA
    );

    modport master (
        output iFLASH,
        output iP0_REQ, iP0_RW, iP0_ADDR, iP0_DATA,
        input  oP0_BUSY, oP0_VALID, oP0_DATA,
        output iP1_REQ, iP1_RW, iP1_ADDR, iP1_DATA,
        input  oP1_BUSY, oP1_VALID, oP1_DATA,
        input  oBUS_REQ, oBUS_RW, oBUS_ADDR, oBUS_DATA,
        output iBUS_BUSY, iBUS_VALID, iBUS_DATA
    );
endinterface

// File: rtl/bus_matching_arbiter.sv
// Two-port round-robin arbiter in front of one in-order memory bus.
// Each granted command pushes its port number into a tag FIFO; each
// downstream response pops the FIFO and is steered back to that port.
//
// Handshake semantics:
//   requester side - a port holds iPn_* while oPn_BUSY=1; the cycle it sees
//     oPn_BUSY=0 with iPn_REQ=1 its command is taken.
//   bus side - oBUS_* is a command while oBUS_REQ=1 and is held unchanged
//     until a cycle with iBUS_BUSY=0, which is the transfer cycle.
//   responses - iBUS_VALID is a one-cycle strobe, one per command, in
//     command order; oPn_VALID is a one-cycle strobe one cycle later.
module bus_matching_arbiter #(
    parameter int D  = 8,
    parameter int DN = 3,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic iCLOCK,
    input  logic iRESET_SYNC,
    bus_matching_arbiter_if.slave bus
);

    localparam logic [DN:0] PTR_ONE = {{DN{1'b0}}, 1'b1};

    // Tag FIFO: extra MSB on the pointers distinguishes full from empty.
    logic [DN:0]   wrPtr;
    logic [DN:0]   rdPtr;
    logic [DN:0]   tagCount;
    logic          tagMem [D];
    logic          tagFull;
    logic          tagEmpty;
    logic          popTag;

    // Output command register.
    logic          outValid;
    logic          outRw;
    logic [AW-1:0] outAddr;
    logic [DW-1:0] outData;

    // Response registers.
    logic          p0Valid;
    logic          p1Valid;
    logic [DW-1:0] p0Data;
    logic [DW-1:0] p1Data;

    // 1 means port 1 was granted last, so port 0 wins the next tie.
    logic          lastGrant;

    logic          outFree;
    logic          grantOk;
    logic          grant0;
    logic          grant1;
    logic          doPush;
    logic          doPop;

    // Grant and pop decisions for the current cycle.
    always_comb begin
        tagCount = wrPtr - rdPtr;
        tagFull  = tagCount[DN];
        tagEmpty = (wrPtr == rdPtr);
        popTag   = tagMem[rdPtr[DN-1:0]];
        outFree  = !outValid || !bus.iBUS_BUSY;
        grantOk  = outFree && !tagFull && !bus.iFLASH && !iRESET_SYNC;
        grant0   = grantOk && bus.iP0_REQ && (!bus.iP1_REQ || lastGrant);
        grant1   = grantOk && bus.iP1_REQ && (!bus.iP0_REQ || !lastGrant);
        doPush   = grant0 || grant1;
        doPop    = bus.iBUS_VALID && !tagEmpty && !bus.iFLASH && !iRESET_SYNC;
    end

    // Pointers, output command register, round-robin pointer and responses.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            outValid  <= 1'b0;
            outRw     <= 1'b0;
            outAddr   <= '0;
            outData   <= '0;
            p0Valid   <= 1'b0;
            p1Valid   <= 1'b0;
            p0Data    <= '0;
            p1Data    <= '0;
            lastGrant <= 1'b1;
        end else if (bus.iFLASH) begin
            // Drop every outstanding tag and the held command; the
            // round-robin pointer keeps its value.
            rdPtr    <= wrPtr;
            outValid <= 1'b0;
            p0Valid  <= 1'b0;
            p1Valid  <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr     <= wrPtr + PTR_ONE;
                outValid  <= 1'b1;
                outRw     <= grant1 ? bus.iP1_RW   : bus.iP0_RW;
                outAddr   <= grant1 ? bus.iP1_ADDR : bus.iP0_ADDR;
                outData   <= grant1 ? bus.iP1_DATA : bus.iP0_DATA;
                lastGrant <= grant1;
            end else if (outValid && !bus.iBUS_BUSY) begin
                outValid <= 1'b0;
            end

            p0Valid <= doPop && !popTag;
            p1Valid <= doPop && popTag;
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
                if (popTag) begin
                    p1Data <= bus.iBUS_DATA;
                end else begin
                    p0Data <= bus.iBUS_DATA;
                end
            end
        end
    end

    // Tag storage; contents are meaningless outside the rd..wr window.
    always_ff @(posedge iCLOCK) begin
        if (doPush) begin
            tagMem[wrPtr[DN-1:0]] <= grant1;
        end
    end

    assign bus.oP0_BUSY  = !grant0;
    assign bus.oP1_BUSY  = !grant1;
    assign bus.oP0_VALID = p0Valid;
    assign bus.oP1_VALID = p1Valid;
    assign bus.oP0_DATA  = p0Data;
    assign bus.oP1_DATA  = p1Data;
    assign bus.oBUS_REQ  = outValid;
    assign bus.oBUS_RW   = outRw;
    assign bus.oBUS_ADDR = outAddr;
    assign bus.oBUS_DATA = outData;

endmodule
